// File: rtl/door_timer.sv
// Door timer: tracks open/hold/closed and reports the closed status.
// The hold phase keeps the door open for DOOR_CYCLES after open falls.
module door_timer #(
    parameter int DOOR_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic open,
    output logic close
);

    localparam logic [1:0] S_CLOSED = 2'd0;
    localparam logic [1:0] S_OPEN   = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;
    localparam int TW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

    logic [1:0]    r_state;
    logic [TW-1:0] r_cnt;
    logic          r_close;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_CLOSED;
            r_cnt   <= '0;
            r_close <= 1'b1;
        end else begin
            case (r_state)
                S_CLOSED: begin
                    if (open) begin
                        r_state <= S_OPEN;
                        r_close <= 1'b0;
                    end
                end
                S_OPEN: begin
                    if (!open) begin
                        r_state <= S_HOLD;
                        r_cnt   <= '0;
                    end
                end
                S_HOLD: begin
                    if (open) begin
                        r_state <= S_OPEN;
                        r_cnt   <= '0;
                    end else if (r_cnt == TW'(DOOR_CYCLES - 1)) begin
                        r_state <= S_CLOSED;
                        r_cnt   <= '0;
                        r_close <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + TW'(1);
                    end
                end
                default: begin
                    r_state <= S_CLOSED;
                    r_cnt   <= '0;
                    r_close <= 1'b1;
                end
            endcase
        end
    end

    assign close = r_close;

endmodule

// File: rtl/elevator_datapath.sv
// Elevator datapath: request latch, floor position, travel timing and
// the door timer, feeding status back to the control FSM.
module elevator_datapath #(
    parameter int N_FLOORS    = 8,
    parameter int MOVE_CYCLES = 4,
    parameter int DOOR_CYCLES = 3,
    parameter int FW = (N_FLOORS > 1) ? $clog2(N_FLOORS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_FLOORS-1:0] call_btn,
    input  logic                up,
    input  logic                down,
    input  logic                open,
    output logic                request_i,
    output logic                request_j_gt_i,
    output logic                request_j_lt_i,
    output logic                close,
    output logic [FW-1:0]       floor,
    output logic                arrive,
    output logic                err
);

    localparam int CW = $clog2(MOVE_CYCLES) + 1;

    logic [N_FLOORS-1:0] r_req;
    logic [FW-1:0]       r_floor;
    logic [CW-1:0]       r_move_cnt;
    logic                r_dir_up;
    logic                r_arrive;
    logic                r_err;

    logic [N_FLOORS-1:0] w_clr;
    logic                w_above;
    logic                w_below;
    logic                w_up_only;
    logic                w_dn_only;
    logic                w_legal;
    logic [CW-1:0]       w_base;
    logic                w_done;

    always_comb begin
        w_clr   = '0;
        w_above = 1'b0;
        w_below = 1'b0;
        if (open) begin
            w_clr[r_floor] = 1'b1;
        end
        for (int k = 0; k < N_FLOORS; k++) begin
            if (FW'(k) > r_floor) w_above = w_above | r_req[k];
            if (FW'(k) < r_floor) w_below = w_below | r_req[k];
        end
    end

    // A direction change restarts the trip; this cycle counts as its first.
    always_comb begin
        w_up_only = up & ~down;
        w_dn_only = down & ~up;
        w_legal   = (w_up_only && (r_floor != FW'(N_FLOORS - 1)))
                  || (w_dn_only && (r_floor != '0));
        w_base    = (r_dir_up != w_up_only) ? '0 : r_move_cnt;
        w_done    = (w_base == CW'(MOVE_CYCLES - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req      <= '0;
            r_floor    <= '0;
            r_move_cnt <= '0;
            r_dir_up   <= 1'b0;
            r_arrive   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_req    <= (r_req | call_btn) & ~w_clr;
            r_arrive <= 1'b0;
            if (up && down) begin
                r_err <= 1'b1;
            end
            if (w_legal) begin
                r_dir_up <= w_up_only;
                if (w_done) begin
                    r_move_cnt <= '0;
                    r_arrive   <= 1'b1;
                    if (w_up_only) r_floor <= r_floor + FW'(1);
                    else           r_floor <= r_floor - FW'(1);
                end else begin
                    r_move_cnt <= w_base + CW'(1);
                end
            end else begin
                r_move_cnt <= '0;
            end
        end
    end

    door_timer #(
        .DOOR_CYCLES(DOOR_CYCLES)
    ) u_door (
        .clk  (clk),
        .rst  (rst),
        .open (open),
        .close(close)
    );

    assign request_i      = r_req[r_floor];
    assign request_j_gt_i = w_above;
    assign request_j_lt_i = w_below;
    assign floor          = r_floor;
    assign arrive         = r_arrive;
    assign err            = r_err;

endmodule

// File: doc/elevator_datapath.md
ELEVATOR_DATAPATH -- requirements
Module: elevator_datapath

Interface
REQ-001 Parameter N_FLOORS, default 8, number of floors; floor index width FW = clog2(N_FLOORS).
REQ-002 Parameter MOVE_CYCLES, default 4, clock cycles of travel per floor.
REQ-003 Parameter DOOR_CYCLES, default 3, cycles close stays low after open falls.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 call_btn  input  N_FLOORS  level request per floor; bit k = request for floor k.
REQ-007 up  input  1  move-up command from control FSM.
REQ-008 down  input  1  move-down command from control FSM.
REQ-009 open  input  1  door-open command from control FSM.
REQ-010 request_i  output  1  pending request at current floor.
REQ-011 request_j_gt_i  output  1  pending request at any floor above current.
REQ-012 request_j_lt_i  output  1  pending request at any floor below current.
REQ-013 close  output  1  door closed status back to control FSM.
REQ-014 floor  output  FW  current floor index.
REQ-015 arrive  output  1  one-cycle pulse on each floor change.
REQ-016 err  output  1  sticky flag: up and down asserted together.

Function
REQ-017 Request register req[N_FLOORS-1:0]: bit k set on any cycle call_btn[k]=1; held until cleared.
REQ-018 Bit req[floor] cleared on any cycle open=1; clear wins over simultaneous call_btn[floor].
REQ-019 request_i = req[floor]; request_j_gt_i = OR of req bits above floor; request_j_lt_i = OR below; combinational from registers, zero latency.
REQ-020 Move counter move_cnt (width clog2(MOVE_CYCLES)+1) increments each cycle exactly one of up/down is 1 and move is legal.
REQ-021 When move_cnt reaches MOVE_CYCLES-1 with up: floor <= floor+1, move_cnt <= 0, arrive=1 next cycle; with down: floor-1 likewise.
REQ-022 Up at floor N_FLOORS-1 or down at floor 0: illegal move, floor and move_cnt held at current/0, no arrive, no err.
REQ-023 Neither up nor down: move_cnt <= 0; direction change mid-count: move_cnt <= 0 then counts new direction.
REQ-024 up=down=1: floor and move_cnt held (move_cnt <= 0), err <= 1, err stays 1 until reset.
REQ-025 open=1 has no effect on movement; control FSM guarantees exclusivity, datapath does not gate.
REQ-026 Door timer states CLOSED, OPEN, HOLD: CLOSED->OPEN when open=1 (close=0 next cycle); OPEN->HOLD when open=0; HOLD counts DOOR_CYCLES cycles then CLOSED (close=1); open=1 in HOLD returns to OPEN, counter cleared.
REQ-027 close = 1 only in CLOSED.
REQ-028 arrive is registered; floor update and arrive assert in the same cycle.

Reset
REQ-029 rst=1 asynchronously forces req=0, floor=0, move_cnt=0, door state CLOSED (close=1), arrive=0, err=0.
REQ-030 Reset mid-move or mid-door-hold discards the partial count; first cycle after rst release behaves as from idle.

Structure
REQ-031 No shared package; door state encoding is a localparam inside the door sub-module.
REQ-032 Door timer is one sub-module door_timer (clk, rst, open, close; parameter DOOR_CYCLES) instantiated once.
REQ-033 Request register, masks, floor/move counters live in elevator_datapath top.

Verification (N_FLOORS=8, MOVE_CYCLES=4, DOOR_CYCLES=3)
REQ-034 Reset, call_btn[5] one cycle at floor 0 -> request_j_gt_i=1, request_i=0, request_j_lt_i=0 next cycle.
REQ-035 up held 8 cycles from floor 0 -> floor 1 after cycle 4, floor 2 after cycle 8, two arrive pulses, move_cnt 0 at each change.
REQ-036 At floor 2 with req[2]=1, open 1 cycle with call_btn[2]=1 same cycle -> req[2]=0, close=0 for 1+3 cycles then 1.
REQ-037 up held at floor 7 for 10 cycles -> floor stays 7, no arrive, err=0; then up=down=1 one cycle -> err=1 and stays 1.
REQ-038 up 2 cycles then down 4 cycles from floor 3 -> no change after up, floor 2 after the 4th down cycle.
REQ-039 rst pulse during move_cnt=2 and during door HOLD -> all outputs at reset values immediately, close=1.
